// File: rtl/dma_pkg.sv
// Types and CNT register field positions for the DMA channel.
// Pure definitions; no logic, no latency.
// Backpressure: not applicable.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    REQ   = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_t;

  typedef enum logic [1:0] {
    AC_INC        = 2'd0,
    AC_DEC        = 2'd1,
    AC_FIXED      = 2'd2,
    AC_INC_RELOAD = 2'd3
  } dma_addr_ctl_t;

  typedef enum logic [1:0] {
    TM_IMM     = 2'd0,
    TM_VBLANK  = 2'd1,
    TM_HBLANK  = 2'd2,
    TM_SPECIAL = 2'd3
  } dma_timing_t;

  // CPU register select codes
  localparam logic [1:0] CFG_SAD = 2'd0;
  localparam logic [1:0] CFG_DAD = 2'd1;
  localparam logic [1:0] CFG_CNT = 2'd2;

  // CNT bit positions
  localparam int CNT_DCTL_LO   = 21;
  localparam int CNT_DCTL_HI   = 22;
  localparam int CNT_SCTL_LO   = 23;
  localparam int CNT_SCTL_HI   = 24;
  localparam int CNT_REPEAT    = 25;
  localparam int CNT_SIZE      = 26;
  localparam int CNT_TIMING_LO = 28;
  localparam int CNT_TIMING_HI = 29;
  localparam int CNT_IRQ_EN    = 30;
  localparam int CNT_ENABLE    = 31;

endpackage

// File: rtl/mmu_types_pkg.sv
// Shared transaction types for every master that talks to the MMU router.
// Pure type definitions; no logic, no latency.
// Backpressure: not applicable.
package mmu_types_pkg;

  typedef enum logic [1:0] {
    TK_CPU_FETCH = 2'd0,
    TK_CPU_DATA  = 2'd1,
    TK_PPU       = 2'd2,
    TK_DMA       = 2'd3
  } transaction_kind_t;

endpackage

// File: rtl/bus_if.sv
// Bus between a master (CPU/DMA) and the MMU router.
// Read data is combinational: valid in the same cycle read_en is high.
// Backpressure: none on the bus itself; access is gated by an external arbiter.
interface Bus_if;
  import mmu_types_pkg::*;

  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              read_en;
  logic              write_en;
  transaction_kind_t kind;

  modport Master_side (output addr, output wdata, output read_en, output write_en,
                       output kind, input rdata);
  modport Slave_side  (input addr, input wdata, input read_en, input write_en,
                       input kind, output rdata);
endinterface

// File: rtl/dma_addr_step.sv
// Next-address computation for one DMA address counter (+/-2 or +/-4, or hold).
// Latency: purely combinational.
// Backpressure: none.
module dma_addr_step
  import dma_pkg::*;
(
  input  logic [31:0]   i_addr,
  input  dma_addr_ctl_t i_ctl,
  input  logic          i_size,
  output logic [31:0]   o_addr
);

  logic [31:0] w_delta;

  assign w_delta = i_size ? 32'd4 : 32'd2;

  // step the address; arithmetic wraps naturally mod 2**32
  always_comb begin
    o_addr = i_addr;
    case (i_ctl)
      AC_INC, AC_INC_RELOAD: o_addr = i_addr + w_delta;
      AC_DEC:                o_addr = i_addr - w_delta;
      default:               o_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/dma_channel.sv
// One DMA channel: copies COUNT units from SAD to DAD as a bus master, one-cycle irq on completion.
// Latency: first READ two clock edges after the enabling CNT write (imm timing, grant held); 2 cycles/unit.
// Backpressure: bus_gnt is honoured only at unit boundaries; bus_req is held from REQ through the final WRITE.
module dma_channel
  import dma_pkg::*;
  import mmu_types_pkg::*;
#(
  parameter int          COUNT_BITS = 14,
  parameter logic [31:0] SAD_MASK   = 32'h07FF_FFFF,
  parameter logic [31:0] DAD_MASK   = 32'h07FF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic        vblank_p,
  input  logic        hblank_p,
  input  logic        special_p,
  output logic        bus_req,
  input  logic        bus_gnt,
  Bus_if.Master_side  bus,
  output logic        busy,
  output logic        irq
);

  // count 0 encodes 2**COUNT_BITS units, hence one extra bit
  function automatic logic [COUNT_BITS:0] units(input logic [COUNT_BITS-1:0] c);
    return (c == '0) ? {1'b1, {COUNT_BITS{1'b0}}} : {1'b0, c};
  endfunction

  dma_state_t      r_state, w_next;
  logic [31:0]     r_sad, r_dad, r_cnt;
  logic [31:0]     r_src, r_dst, r_data;
  logic [COUNT_BITS:0] r_rem;

  logic            w_cnt_wr, w_start, w_en_now, w_size, w_trig;
  dma_addr_ctl_t   w_src_raw, w_src_ctl, w_dst_ctl;
  dma_timing_t     w_timing;
  logic [31:0]     w_src_step, w_dst_step, w_src_aligned, w_dst_aligned, w_wdata;
  logic [COUNT_BITS:0] w_rem_dec;

  assign w_cnt_wr  = cfg_we && (cfg_sel == CFG_CNT);
  assign w_start   = w_cnt_wr && cfg_wdata[CNT_ENABLE] && !r_cnt[CNT_ENABLE];
  // an enable-clear written this very cycle must take effect at this edge
  assign w_en_now  = w_cnt_wr ? cfg_wdata[CNT_ENABLE] : r_cnt[CNT_ENABLE];
  assign w_size    = r_cnt[CNT_SIZE];
  assign w_timing  = dma_timing_t'(r_cnt[CNT_TIMING_HI:CNT_TIMING_LO]);
  assign w_dst_ctl = dma_addr_ctl_t'(r_cnt[CNT_DCTL_HI:CNT_DCTL_LO]);
  assign w_src_raw = dma_addr_ctl_t'(r_cnt[CNT_SCTL_HI:CNT_SCTL_LO]);
  // source has no reload mode; code 3 behaves as fixed
  assign w_src_ctl = (w_src_raw == AC_INC_RELOAD) ? AC_FIXED : w_src_raw;
  assign w_rem_dec = r_rem - 1'b1;

  assign w_src_aligned = w_size ? {r_src[31:2], 2'b00} : {r_src[31:1], 1'b0};
  assign w_dst_aligned = w_size ? {r_dst[31:2], 2'b00} : {r_dst[31:1], 1'b0};
  assign w_wdata       = w_size ? r_data : {r_data[15:0], r_data[15:0]};

  assign cfg_rdata = (cfg_sel == CFG_CNT) ? {r_cnt[31:16], 16'h0000} : 32'h0;
  assign busy      = (r_state != IDLE);
  assign bus.kind  = TK_DMA;

  dma_addr_step u_src_step (.i_addr(r_src), .i_ctl(w_src_ctl), .i_size(w_size), .o_addr(w_src_step));
  dma_addr_step u_dst_step (.i_addr(r_dst), .i_ctl(w_dst_ctl), .i_size(w_size), .o_addr(w_dst_step));

  // select the trigger pulse matching the programmed timing mode
  always_comb begin
    w_trig = 1'b0;
    case (w_timing)
      TM_IMM:     w_trig = 1'b1;
      TM_VBLANK:  w_trig = vblank_p;
      TM_HBLANK:  w_trig = hblank_p;
      TM_SPECIAL: w_trig = special_p;
      default:    w_trig = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state and bus outputs; outputs are decoded from state so reset clears them at once
  always_comb begin
    w_next       = r_state;
    bus_req      = 1'b0;
    bus.read_en  = 1'b0;
    bus.write_en = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    irq          = 1'b0;
    case (r_state)
      IDLE:  if (w_start) w_next = ARMED;
      ARMED: begin
        if (!w_en_now)   w_next = IDLE;
        else if (w_trig) w_next = REQ;
      end
      REQ: begin
        bus_req = 1'b1;
        if (!w_en_now)    w_next = IDLE;
        else if (bus_gnt) w_next = READ;
      end
      READ: begin
        bus_req     = 1'b1;
        bus.read_en = 1'b1;
        bus.addr    = w_src_aligned;
        w_next      = WRITE;
      end
      WRITE: begin
        bus_req      = 1'b1;
        bus.write_en = 1'b1;
        bus.addr     = w_dst_aligned;
        bus.wdata    = w_wdata;
        if (!w_en_now)            w_next = IDLE;
        else if (w_rem_dec == '0) w_next = DONE;
        else if (bus_gnt)         w_next = READ;
        else                      w_next = REQ;
      end
      DONE: begin
        irq = r_cnt[CNT_IRQ_EN];
        if (w_en_now && r_cnt[CNT_REPEAT] && (w_timing != TM_IMM)) w_next = ARMED;
        else                                                       w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // CPU registers, live counters and the read-data holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sad  <= 32'h0;
      r_dad  <= 32'h0;
      r_cnt  <= 32'h0;
      r_src  <= 32'h0;
      r_dst  <= 32'h0;
      r_data <= 32'h0;
      r_rem  <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_sel)
          CFG_SAD: r_sad <= cfg_wdata;
          CFG_DAD: r_dad <= cfg_wdata;
          CFG_CNT: r_cnt <= cfg_wdata;
          default: ;
        endcase
      end
      if (r_state == DONE && w_next == IDLE) r_cnt[CNT_ENABLE] <= 1'b0;
      if (r_state == IDLE && w_start) begin
        r_src <= r_sad & SAD_MASK;
        r_dst <= r_dad & DAD_MASK;
        r_rem <= units(cfg_wdata[COUNT_BITS-1:0]);
      end
      if (r_state == READ) begin
        if (w_size) r_data <= bus.rdata;
        else        r_data <= {16'h0000, r_src[1] ? bus.rdata[31:16] : bus.rdata[15:0]};
      end
      if (r_state == WRITE) begin
        r_src <= w_src_step & SAD_MASK;
        r_dst <= w_dst_step & DAD_MASK;
        r_rem <= w_rem_dec;
      end
      if (r_state == DONE && w_next == ARMED) begin
        r_rem <= units(r_cnt[COUNT_BITS-1:0]);
        if (w_dst_ctl == AC_INC_RELOAD) r_dst <= r_dad & DAD_MASK;
      end
    end
  end

endmodule
